calc_result_display: RTL and testbench
======================================

Name: calc_result_display

Overview:
Output stage directly downstream of the calculator datapath. It accepts the 8-bit result through a valid/ready handshake and converts it to three BCD digits with a sequential double-dabble, one shift per cycle. It holds the last converted value and time-multiplexes it onto a common 7-segment display with leading-zero blanking.

Parameters:
REFRESH_DIV, 16, clock cycles each digit stays selected before the scan advances (legal range 2..65535)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
res_valid  input  1  result from calculator datapath is valid
res_data  input  8  unsigned result, 0..255
res_ready  output  1  block can accept a result
busy  output  1  conversion in progress
bcd_out  output  12  {hundreds, tens, units} BCD of last completed conversion
seg  output  7  segments {g,f,e,d,c,b,a}, active high
dig_sel  output  3  one-hot digit enable, active high: bit0 units, bit1 tens, bit2 hundreds

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state updates on the rising edge of clk.
- FSM with two states: IDLE and CONVERT. res_ready = (state==IDLE); busy = (state==CONVERT).
- Accept occurs on an edge where res_valid & res_ready. On accept: load 20-bit shift register {12'b0, res_data}, step counter = 0, go to CONVERT.
- CONVERT, each cycle: every BCD nibble >= 5 gets +3, then the whole register shifts left 1; counter++.
- After the 8th step (counter==7): bcd_out <= adjusted+shifted upper 12 bits; state -> IDLE in the same edge.
- Latency: bcd_out updates exactly 8 edges after the accept edge. res_ready is low for those 8 cycles and returns high with the new bcd_out.
- res_valid while busy is ignored. Upstream holds res_data and res_valid until the next accept. A result can be accepted again on the first IDLE cycle, so throughput is 1 result per 9 cycles.
- res_data is sampled only at accept; later changes do not affect the conversion in flight.
- bcd_out only changes on completion; the display shows the old value during conversion.
- Scan: refresh counter counts 0..REFRESH_DIV-1. At wrap, the digit index advances units->tens->hundreds->units. dig_sel is one-hot for the current index.
- Decode for 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex); blank = 00. Nibbles >9 cannot occur; decode them as blank.
- Blanking: hundreds blank if 0; tens blank if hundreds==0 and tens==0; units never blank.
- Reset values: state IDLE, res_ready=1, busy=0, bcd_out=000, refresh counter 0, digit index units (dig_sel=001), seg=3F.
- Reset during CONVERT aborts the conversion: bcd_out=000, res_ready=1 after the reset edge, and the aborted value is never displayed.
- Reset asserted together with res_valid: reset wins and nothing is accepted.

Test Plan:
1. Hold rst 2 cycles, release -> res_ready=1, busy=0, bcd_out=000, dig_sel=001, seg=3F; with REFRESH_DIV=4, dig_sel=010 after 4 cycles with seg=00.
2. res_data=255 with res_valid for 1 cycle -> busy for 8 cycles, then bcd_out=255 and res_ready=1; scan shows units 6D, tens 6D, hundreds 5B.
3. res_data=7 -> bcd_out=007; units 07, tens 00, hundreds 00 (blanked).
4. Send 100, keep res_valid high with res_data=42 during conversion -> 100 completes at +8 (units 3F, tens 3F unblanked, hundreds 06). 42 is accepted on the next IDLE cycle, and bcd_out=042 at +17 from the first accept (tens 66, hundreds blank).
5. Start conversion of 200 with bcd_out=055 held, assert rst at step 4 -> bcd_out=000, res_ready=1, display units 3F, value 200 never appears.
6. REFRESH_DIV=4, bcd_out=123 -> dig_sel 001×4, 010×4, 100×4, then 001 again; seg 4F, 5B, 06 respectively.

Source files
------------

// File: rtl/calc_result_display.sv
// Calculator result output stage: accepts an 8-bit result, converts it
// to BCD by sequential double-dabble and scans it onto a 7-seg display.
module calc_result_display #(
    parameter int REFRESH_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        res_valid,
    input  logic [7:0]  res_data,
    output logic        res_ready,
    output logic        busy,
    output logic [11:0] bcd_out,
    output logic [6:0]  seg,
    output logic [2:0]  dig_sel
);

    typedef enum logic {IDLE, CONVERT} state_t;

    localparam logic [15:0] REF_MAX = 16'(REFRESH_DIV - 1);

    state_t      state;
    state_t      state_next;
    logic [19:0] sr;
    logic [19:0] sr_adj;
    logic [19:0] sr_next;
    logic [2:0]  cnt;
    logic        accept;
    logic        done;
    logic [15:0] refresh;
    logic [1:0]  idx;
    logic [3:0]  nib;
    logic        blank;

    function automatic logic [3:0] adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] dec(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign accept = res_valid && (state == IDLE);
    assign done   = (state == CONVERT) && (cnt == 3'd7);

    // One double-dabble step: adjust BCD nibbles, then shift left
    always_comb begin
        sr_adj  = {adj(sr[19:16]), adj(sr[15:12]), adj(sr[11:8]), sr[7:0]};
        sr_next = sr_adj << 1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CONVERT;
            CONVERT: if (done)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        res_ready = (state == IDLE);
        busy      = (state == CONVERT);
    end

    // Conversion shift register, step counter and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            cnt     <= '0;
            bcd_out <= '0;
        end else if (accept) begin
            sr  <= {12'b0, res_data};
            cnt <= '0;
        end else if (state == CONVERT) begin
            sr  <= sr_next;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) bcd_out <= sr_next[19:8];
        end
    end

    // Refresh divider and digit index for the display scan
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh <= '0;
            idx     <= '0;
        end else if (refresh == REF_MAX) begin
            refresh <= '0;
            idx     <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end else begin
            refresh <= refresh + 16'd1;
        end
    end

    // Digit select, blanking and segment decode
    always_comb begin
        nib     = 4'd0;
        blank   = 1'b1;
        dig_sel = 3'b000;
        case (idx)
            2'd0: begin
                nib     = bcd_out[3:0];
                blank   = 1'b0;
                dig_sel = 3'b001;
            end
            2'd1: begin
                nib     = bcd_out[7:4];
                blank   = (bcd_out[11:8] == 4'd0) && (bcd_out[7:4] == 4'd0);
                dig_sel = 3'b010;
            end
            2'd2: begin
                nib     = bcd_out[11:8];
                blank   = (bcd_out[11:8] == 4'd0);
                dig_sel = 3'b100;
            end
            default: begin
                nib     = 4'd0;
                blank   = 1'b1;
                dig_sel = 3'b000;
            end
        endcase
        seg = blank ? 7'h00 : dec(nib);
    end

endmodule

// File: tb/tb_calc_result_display.sv
// Directed testbench for calc_result_display with REFRESH_DIV=4.
// Inputs driven and outputs sampled on the falling edge.
module tb_calc_result_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_ready;
    logic        busy;
    logic [11:0] bcd_out;
    logic [6:0]  seg;
    logic [2:0]  dig_sel;

    int errors = 0;
    int checks = 0;

    calc_result_display #(.REFRESH_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy),
        .bcd_out   (bcd_out),
        .seg       (seg),
        .dig_sel   (dig_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Send one result and follow it through the 8-cycle conversion
    task automatic send(input logic [7:0] d, input logic [11:0] old_bcd,
                        input logic [11:0] exp_bcd);
        res_valid = 1'b1;
        res_data  = d;
        @(negedge clk);
        res_valid = 1'b0;
        res_data  = 8'hAA;
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", res_ready, 0);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk("busy_during", busy, 1);
            chk("bcd_held", bcd_out, old_bcd);
        end
        @(negedge clk);
        chk("ready_done", res_ready, 1);
        chk("busy_done", busy, 0);
        chk("bcd_done", bcd_out, exp_bcd);
    endtask

    // Align to the start of a units window, then check a full scan
    task automatic scan(input logic [6:0] su, input logic [6:0] st,
                        input logic [6:0] sh);
        logic       found;
        logic [6:0] exp_seg [3];
        logic [2:0] exp_sel [3];
        exp_seg[0] = su; exp_seg[1] = st; exp_seg[2] = sh;
        exp_sel[0] = 3'b001; exp_sel[1] = 3'b010; exp_sel[2] = 3'b100;
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk);
            if (dig_sel == 3'b100) found = 1'b1;
        end
        chk("scan_sync_h", 32'(found), 1);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (dig_sel == 3'b001) found = 1'b1;
        end
        chk("scan_sync_u", 32'(found), 1);
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 4; k++) begin
                if (d != 0 || k != 0) @(negedge clk);
                chk("scan_sel", dig_sel, exp_sel[d]);
                chk("scan_seg", seg, exp_seg[d]);
            end
        end
        @(negedge clk);
        chk("scan_wrap", dig_sel, 3'b001);
    endtask

    initial begin
        rst       = 1'b1;
        res_valid = 1'b0;
        res_data  = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", res_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_bcd", bcd_out, 12'h000);
        chk("rst_sel", dig_sel, 3'b001);
        chk("rst_seg", seg, 7'h3F);
        repeat (3) @(negedge clk);
        chk("sel_before_wrap", dig_sel, 3'b001);
        @(negedge clk);
        chk("sel_after_wrap", dig_sel, 3'b010);
        chk("seg_tens_blank", seg, 7'h00);

        send(8'd255, 12'h000, 12'h255);
        scan(7'h6D, 7'h6D, 7'h5B);

        send(8'd7, 12'h255, 12'h007);
        scan(7'h07, 7'h00, 7'h00);

        send(8'd100, 12'h007, 12'h100);
        scan(7'h3F, 7'h3F, 7'h06);

        res_valid = 1'b1;
        res_data  = 8'd100;
        @(negedge clk);
        res_data = 8'd42;
        chk("b2b_busy", busy, 1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk("b2b_busy_during", busy, 1);
        end
        @(negedge clk);
        chk("b2b_first_bcd", bcd_out, 12'h100);
        chk("b2b_first_ready", res_ready, 1);
        @(negedge clk);
        res_valid = 1'b0;
        chk("b2b_second_busy", busy, 1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk("b2b_second_hold", bcd_out, 12'h100);
        end
        @(negedge clk);
        chk("b2b_second_bcd", bcd_out, 12'h042);
        chk("b2b_second_ready", res_ready, 1);
        scan(7'h5B, 7'h66, 7'h00);

        send(8'd55, 12'h042, 12'h055);
        res_valid = 1'b1;
        res_data  = 8'd200;
        @(negedge clk);
        res_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy", busy, 1);
        chk("abort_bcd_old", bcd_out, 12'h055);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_bcd", bcd_out, 12'h000);
        chk("abort_ready", res_ready, 1);
        chk("abort_busy_lo", busy, 0);
        chk("abort_sel", dig_sel, 3'b001);
        chk("abort_seg", seg, 7'h3F);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_never", bcd_out, 12'h000);
        end

        rst       = 1'b1;
        res_valid = 1'b1;
        res_data  = 8'd99;
        @(negedge clk);
        rst       = 1'b0;
        res_valid = 1'b0;
        chk("rst_wins_ready", res_ready, 1);
        chk("rst_wins_busy", busy, 0);
        repeat (9) @(negedge clk);
        chk("rst_wins_bcd", bcd_out, 12'h000);

        send(8'd123, 12'h000, 12'h123);
        scan(7'h4F, 7'h5B, 7'h06);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
